// File: rtl/kbd_pkg.sv
// kbd_pkg -- shared definitions for the PS/2 set-2 keyboard decoder.
//   kbd_state_e : decoder FSM states
//   KC_*        : scan-code constants (prefixes, status bytes, shift keys)
//   ASC_*       : ASCII codes used by the optional lookup table
//   is_status() : true for controller/keyboard status bytes that carry no key
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_DECODE = 2'd2,
        ST_EMIT   = 2'd3
    } kbd_state_e;

    localparam logic [7:0] KC_E0     = 8'hE0;
    localparam logic [7:0] KC_F0     = 8'hF0;
    localparam logic [7:0] KC_E1     = 8'hE1;
    localparam logic [7:0] KC_AA     = 8'hAA;
    localparam logic [7:0] KC_FA     = 8'hFA;
    localparam logic [7:0] KC_FE     = 8'hFE;
    localparam logic [7:0] KC_EE     = 8'hEE;
    localparam logic [7:0] KC_LSHIFT = 8'h12;
    localparam logic [7:0] KC_RSHIFT = 8'h59;

    // Bytes of the pause sequence that follow its E1 lead-in.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [7:0] ASC_NONE  = 8'h00;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_ENTER = 8'h0D;
    localparam logic [7:0] ASC_BKSP  = 8'h08;

    function automatic logic is_status(input logic [7:0] b);
        return (b == KC_AA) || (b == KC_FA) || (b == KC_FE) || (b == KC_EE) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/kbd_ascii_rom.sv
// kbd_ascii_rom -- combinational set-2 scan code to ASCII lookup.
//   code_i  [7:0] : set-2 make code (non-extended)
//   shift_i       : shift held -> upper case letters / digit-row symbols
//   ascii_o [7:0] : ASCII character, 00 for unmapped codes
module kbd_ascii_rom
    import kbd_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);

    // {unshifted, shifted} character pair for the current code
    logic [15:0] pair;

    always_comb begin
        pair = {ASC_NONE, ASC_NONE};
        case (code_i)
            8'h1C: pair = {8'h61, 8'h41};   // a
            8'h32: pair = {8'h62, 8'h42};   // b
            8'h21: pair = {8'h63, 8'h43};   // c
            8'h23: pair = {8'h64, 8'h44};   // d
            8'h24: pair = {8'h65, 8'h45};   // e
            8'h2B: pair = {8'h66, 8'h46};   // f
            8'h34: pair = {8'h67, 8'h47};   // g
            8'h33: pair = {8'h68, 8'h48};   // h
            8'h43: pair = {8'h69, 8'h49};   // i
            8'h3B: pair = {8'h6A, 8'h4A};   // j
            8'h42: pair = {8'h6B, 8'h4B};   // k
            8'h4B: pair = {8'h6C, 8'h4C};   // l
            8'h3A: pair = {8'h6D, 8'h4D};   // m
            8'h31: pair = {8'h6E, 8'h4E};   // n
            8'h44: pair = {8'h6F, 8'h4F};   // o
            8'h4D: pair = {8'h70, 8'h50};   // p
            8'h15: pair = {8'h71, 8'h51};   // q
            8'h2D: pair = {8'h72, 8'h52};   // r
            8'h1B: pair = {8'h73, 8'h53};   // s
            8'h2C: pair = {8'h74, 8'h54};   // t
            8'h3C: pair = {8'h75, 8'h55};   // u
            8'h2A: pair = {8'h76, 8'h56};   // v
            8'h1D: pair = {8'h77, 8'h57};   // w
            8'h22: pair = {8'h78, 8'h58};   // x
            8'h35: pair = {8'h79, 8'h59};   // y
            8'h1A: pair = {8'h7A, 8'h5A};   // z
            8'h16: pair = {8'h31, 8'h21};   // 1 !
            8'h1E: pair = {8'h32, 8'h40};   // 2 @
            8'h26: pair = {8'h33, 8'h23};   // 3 #
            8'h25: pair = {8'h34, 8'h24};   // 4 $
            8'h2E: pair = {8'h35, 8'h25};   // 5 %
            8'h36: pair = {8'h36, 8'h5E};   // 6 ^
            8'h3D: pair = {8'h37, 8'h26};   // 7 &
            8'h3E: pair = {8'h38, 8'h2A};   // 8 *
            8'h46: pair = {8'h39, 8'h28};   // 9 (
            8'h45: pair = {8'h30, 8'h29};   // 0 )
            8'h29: pair = {ASC_SPACE, ASC_SPACE};
            8'h5A: pair = {ASC_ENTER, ASC_ENTER};
            8'h66: pair = {ASC_BKSP,  ASC_BKSP};
            default: pair = {ASC_NONE, ASC_NONE};
        endcase
        ascii_o = shift_i ? pair[7:0] : pair[15:8];
    end

endmodule

// File: rtl/kbd_decoder.sv
// kbd_decoder -- pops PS/2 set-2 scan codes from a byte FIFO and turns them
// into key events with extended/break flags, live shift state and optional
// ASCII translation.
//
// Optional feature: define KBD_ASCII_EN to drive ev_ascii from the
// kbd_ascii_rom lookup; otherwise ev_ascii is tied to 00.
//
// Ports:
//   clk            system clock, rising edge
//   clrn           asynchronous active-low reset
//   ps2_ready      FIFO non-empty
//   ps2_data [7:0] FIFO head byte
//   ps2_rdn        registered active-low FIFO pop strobe
//   ev_valid       key event available (held until ev_ack)
//   ev_ack         consumer accepts the event
//   ev_code  [7:0] set-2 key code
//   ev_ext         E0-prefixed (or pause) event
//   ev_break       1 = release, 0 = press
//   shift          left or right shift currently held
//   ev_ascii [7:0] ASCII of the event, 00 if not mapped
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a byte in the FIFO
// POP      | ps2_rdn low for this cycle, head byte already captured
// DECODE   | classify captured byte: prefix, status, pause skip or key
// EMIT     | event presented, waiting for ev_ack
module kbd_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 1000000
)
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    output logic       ps2_rdn,
    output logic       ev_valid,
    input  logic       ev_ack,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       shift,
    output logic [7:0] ev_ascii
);

    localparam int unsigned      TMO_W    = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(PREFIX_TIMEOUT - 1);

    kbd_state_e       state_q, state_d;
    logic             rdn_q, rdn_d;
    logic [7:0]       data_q, data_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [2:0]       skip_q, skip_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             valid_q, valid_d;
    logic [7:0]       code_q, code_d;
    logic             evext_q, evext_d;
    logic             evbrk_q, evbrk_d;
    logic             shl_q, shl_d;
    logic             shr_q, shr_d;
    logic             pending;

    assign pending = ext_q | brk_q | (skip_q != 3'd0);

    always_comb begin
        state_d = state_q;
        rdn_d   = 1'b1;
        data_d  = data_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        valid_d = valid_q;
        code_d  = code_q;
        evext_d = evext_q;
        evbrk_d = evbrk_q;
        shl_d   = shl_q;
        shr_d   = shr_q;

        // Stale-prefix timer: reloaded on every pop, counts down only while
        // something is pending, and drops the pending state at terminal count.
        if (!pending || state_q == ST_POP) begin
            tmo_d = TMO_LOAD;
        end else if (tmo_q == '0) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = 3'd0;
            tmo_d  = TMO_LOAD;
        end else begin
            tmo_d = tmo_q - TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (ps2_ready) begin
                    state_d = ST_POP;
                    rdn_d   = 1'b0;
                    data_d  = ps2_data;
                end
            end
            ST_POP: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (skip_q != 3'd0) begin
                    skip_d = skip_q - 3'd1;
                end else if (data_q == KC_E0) begin
                    ext_d = 1'b1;
                end else if (data_q == KC_F0) begin
                    brk_d = 1'b1;
                end else if (is_status(data_q)) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (data_q == KC_E1) begin
                    // Pause: one synthetic make event, rest of sequence dropped.
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                    code_d  = KC_E1;
                    evext_d = 1'b1;
                    evbrk_d = 1'b0;
                    skip_d  = PAUSE_SKIP;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                end else begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                    code_d  = data_q;
                    evext_d = ext_q;
                    evbrk_d = brk_q;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    if (!ext_q && data_q == KC_LSHIFT) shl_d = ~brk_q;
                    if (!ext_q && data_q == KC_RSHIFT) shr_d = ~brk_q;
                end
            end
            ST_EMIT: begin
                if (ev_ack) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            rdn_q   <= 1'b1;
            data_q  <= 8'h00;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            skip_q  <= 3'd0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 8'h00;
            evext_q <= 1'b0;
            evbrk_q <= 1'b0;
            shl_q   <= 1'b0;
            shr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdn_q   <= rdn_d;
            data_q  <= data_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            evext_q <= evext_d;
            evbrk_q <= evbrk_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
        end
    end

    assign ps2_rdn  = rdn_q;
    assign ev_valid = valid_q;
    assign ev_code  = code_q;
    assign ev_ext   = evext_q;
    assign ev_break = evbrk_q;
    assign shift    = shl_q | shr_q;

`ifdef KBD_ASCII_EN
    logic [7:0] rom_ascii;
    logic [7:0] ascii_q, ascii_d;

    // Looked up with the shift state held before this byte; shift keys
    // themselves are unmapped so their own update never matters here.
    kbd_ascii_rom u_ascii_rom (
        .code_i  (data_q),
        .shift_i (shl_q | shr_q),
        .ascii_o (rom_ascii)
    );

    always_comb begin
        ascii_d = ascii_q;
        if (state_q == ST_DECODE && state_d == ST_EMIT) begin
            ascii_d = (ext_q || brk_q) ? ASC_NONE : rom_ascii;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ascii_q <= ASC_NONE;
        end else begin
            ascii_q <= ascii_d;
        end
    end

    assign ev_ascii = ascii_q;
`else
    assign ev_ascii = ASC_NONE;
`endif

endmodule

// File: tb/tb_kbd_decoder.sv
module tb_kbd_decoder;

    localparam int TMO = 64;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       sh;
        logic [7:0] asc;
    } ev_t;

    logic       clk;
    logic       clrn;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       ps2_rdn;
    logic       ev_valid;
    logic       ev_ack;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       shift;
    logic [7:0] ev_ascii;

    int n_checks = 0;
    int n_errors = 0;
    int rdn_low  = 0;
    int ev_rise  = 0;
    logic ack_en = 1'b1;
    logic prev_valid = 1'b0;

    logic [7:0] fifo[$];
    ev_t        exp_q[$];

    kbd_decoder #(.PREFIX_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_ready (ps2_ready),
        .ps2_data  (ps2_data),
        .ps2_rdn   (ps2_rdn),
        .ev_valid  (ev_valid),
        .ev_ack    (ev_ack),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .shift     (shift),
        .ev_ascii  (ev_ascii)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                             input logic sh, input logic [7:0] asc);
        ev_t e;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        e.sh   = sh;
`ifdef KBD_ASCII_EN
        e.asc  = asc;
`else
        e.asc  = (asc == 8'h00) ? 8'h00 : 8'h00;
`endif
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || ev_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check({tag, "_timeout"}, n, 0);
            fifo.delete();
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ev_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, n, 0);
    endtask

    // FIFO model: the pop strobe is low for the whole POP cycle, so sampling
    // it on the falling edge sees each pulse exactly once per low cycle.
    initial begin
        ps2_ready = 1'b0;
        ps2_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!ps2_rdn) begin
                rdn_low++;
                if (fifo.size() > 0) void'(fifo.pop_front());
            end
            ps2_ready = (fifo.size() != 0);
            ps2_data  = ps2_ready ? fifo[0] : 8'h00;
        end
    end

    // Consumer: compares each event against the scoreboard and acks it.
    initial begin
        ev_t e;
        ev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ev_valid && !prev_valid) ev_rise++;
            prev_valid = ev_valid;
            if (ev_ack) begin
                ev_ack = 1'b0;
            end else if (ev_valid && ack_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_code",  32'(ev_code),  32'(e.code));
                    check("ev_ext",   32'(ev_ext),   32'(e.ext));
                    check("ev_break", 32'(ev_break), 32'(e.brk));
                    check("ev_shift", 32'(shift),    32'(e.sh));
                    check("ev_ascii", 32'(ev_ascii), 32'(e.asc));
                end
                ev_ack = 1'b1;
            end
        end
    end

    initial begin
        int r0;
        int c0;
        int bad;
        logic [18:0] snap;

        clrn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdn",   32'(ps2_rdn),  1);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_code",  32'(ev_code),  0);
        check("rst_ext",   32'(ev_ext),   0);
        check("rst_break", 32'(ev_break), 0);
        check("rst_shift", 32'(shift),    0);
        check("rst_ascii", 32'(ev_ascii), 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // make / break of 'a'
        push(8'h1C); push(8'hF0); push(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_idle("a_make_break");

        // shifted 'A'
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
        expect_ev(8'h12, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_ev(8'h1C, 1'b0, 1'b0, 1'b1, 8'h41);
        expect_ev(8'h12, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_idle("shift_a");
        check("shift_released", 32'(shift), 0);

        // E0 F0 75: one event, three pops
        r0 = rdn_low;
        c0 = ev_rise;
        push(8'hE0); push(8'hF0); push(8'h75);
        expect_ev(8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_idle("e0f0");
        check("e0f0_rdn_pulses", rdn_low - r0, 3);
        check("e0f0_events",     ev_rise - c0, 1);

        // reversed prefix order
        push(8'hF0); push(8'hE0); push(8'h75);
        expect_ev(8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
        wait_idle("f0e0");

        // status bytes clear pending prefixes
        push(8'hE0); push(8'hAA); push(8'h75);
        expect_ev(8'h75, 1'b0, 1'b0, 1'b0, 8'h00);
        push(8'hF0); push(8'hFA); push(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        wait_idle("status");

        // pause: one event, next seven bytes dropped
        push(8'hE1);
        push(8'h14); push(8'h77); push(8'hE1); push(8'hF0);
        push(8'h14); push(8'hF0); push(8'h77);
        push(8'h1C);
        expect_ev(8'hE1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        wait_idle("pause");

        // prefix still alive well before the timeout
        push(8'hE0);
        wait_idle("e0_short");
        repeat (20) @(negedge clk);
        push(8'h75);
        expect_ev(8'h75, 1'b1, 1'b0, 1'b0, 8'h00);
        wait_idle("e0_short_key");

        // prefix expired after the timeout
        push(8'hE0);
        wait_idle("e0_long");
        repeat (TMO + 10) @(negedge clk);
        push(8'h75);
        expect_ev(8'h75, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_idle("e0_long_key");

        // back-pressure: unacked event blocks further pops
        ack_en = 1'b0;
        push(8'h1C); push(8'h32);
        expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        expect_ev(8'h32, 1'b0, 1'b0, 1'b0, 8'h62);
        wait_valid("bp_first");
        snap = {ev_code, ev_ext, ev_break, ev_ascii, ev_valid};
        r0   = rdn_low;
        bad  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({ev_code, ev_ext, ev_break, ev_ascii, ev_valid} !== snap) bad++;
        end
        check("bp_rdn_low",   rdn_low - r0, 0);
        check("bp_ev_stable", bad, 0);
        check("bp_fifo_held", fifo.size(), 1);
        ack_en = 1'b1;
        wait_idle("bp_drain");

        // reset while an event is presented
        push(8'h12);
        expect_ev(8'h12, 1'b0, 1'b0, 1'b1, 8'h00);
        wait_idle("rst_shift_make");
        ack_en = 1'b0;
        push(8'h1C);
        wait_valid("rst_emit");
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst_valid", 32'(ev_valid), 0);
        check("async_rst_shift", 32'(shift),    0);
        check("async_rst_code",  32'(ev_code),  0);
        check("async_rst_rdn",   32'(ps2_rdn),  1);
        #1;
        clrn = 1'b1;
        @(negedge clk);
        ack_en = 1'b1;
        c0 = ev_rise;
        push(8'hAA);
        repeat (20) @(negedge clk);
        check("aa_no_event", ev_rise - c0, 0);
        check("aa_consumed", fifo.size(), 0);
        check("aa_valid",    32'(ev_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
